// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch block.
//   - state_t     : fetch sequencer states
//   - XLEN/INSTR_W: address and instruction widths
//   - RESET_PC_DEFAULT / PC_STEP_DEFAULT : default parameter values
//   - align_pc()  : clears the two byte-offset bits of an address
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP_DEFAULT  = 32'd4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // request may be issued
    ST_WAIT  = 2'd1,  // request granted, waiting for rvalid
    ST_HOLD  = 2'd2,  // buffer and hold register both occupied
    ST_DROP  = 2'd3   // redirected while a response is still owed
  } state_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory request/response bus.
//   imem_req/imem_addr     : fetch request (master -> slave)
//   imem_gnt               : request accepted this cycle (slave -> master)
//   imem_rvalid/imem_rdata : read response, no backpressure (slave -> master)
interface fetch_if;
  import fetch_pkg::*;

  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: registered fetch-latch output entry plus one hold slot.
//   clk, reset   : clock, synchronous active-high reset
//   flush        : invalidate the entry and discard the hold slot
//   stall        : downstream stall; the entry is consumed when valid & ~stall
//   load         : write {in_pc, in_instr} straight into the output entry
//   hold_load    : write {in_pc, in_instr} into the hold slot
//   promote      : move the hold slot into the output entry
//   valid/pc/instr : registered output entry
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               stall,
  input  logic               load,
  input  logic               hold_load,
  input  logic               promote,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               valid,
  output logic [XLEN-1:0]    pc,
  output logic [INSTR_W-1:0] instr
);

  logic               valid_reg;
  logic [XLEN-1:0]    pc_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic [XLEN-1:0]    hold_pc_reg;
  logic [INSTR_W-1:0] hold_instr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg      <= 1'b0;
      pc_reg         <= '0;
      instr_reg      <= '0;
      hold_pc_reg    <= '0;
      hold_instr_reg <= '0;
    end else if (flush) begin
      valid_reg      <= 1'b0;
      hold_pc_reg    <= '0;
      hold_instr_reg <= '0;
    end else begin
      // A new entry replaces the one being consumed at the same edge.
      if (load) begin
        valid_reg <= 1'b1;
        pc_reg    <= in_pc;
        instr_reg <= in_instr;
      end else if (promote) begin
        valid_reg <= 1'b1;
        pc_reg    <= hold_pc_reg;
        instr_reg <= hold_instr_reg;
      end else if (valid_reg && !stall) begin
        valid_reg <= 1'b0;
        pc_reg    <= '0;
        instr_reg <= '0;
      end
      if (hold_load) begin
        hold_pc_reg    <= in_pc;
        hold_instr_reg <= in_instr;
      end
    end
  end

  assign valid = valid_reg;
  assign pc    = pc_reg;
  assign instr = instr_reg;

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: IF-stage fetch sequencer driving the IF/ID fetch latch.
//   clk, reset          : clock, synchronous active-high reset
//   stall               : downstream stall, latch holds while high
//   redirect/redirect_pc: one-cycle redirect pulse and target
//   imem                : instruction memory bus (fetch_if.master)
//   fl_valid/fl_pc/fl_instr : registered fetch latch entry
//   fl_flush            : latch clear, reset | redirect
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  fetch_if.master            imem,
  output logic               fl_valid,
  output logic [XLEN-1:0]    fl_pc,
  output logic [INSTR_W-1:0] fl_instr,
  output logic               fl_flush
);

  state_t          state_reg;
  state_t          state_next;
  logic [XLEN-1:0] pc_reg;

  logic buf_valid;
  logic consume;
  logic buf_load;
  logic hold_load;
  logic promote;

  assign consume = buf_valid & ~stall;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; redirect wins over every other transition.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH: begin
        if (!redirect && imem.imem_gnt) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect) begin
          state_next = imem.imem_rvalid ? ST_FETCH : ST_DROP;
        end else if (imem.imem_rvalid) begin
          state_next = (!buf_valid || consume) ? ST_FETCH : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect || !stall) state_next = ST_FETCH;
      end
      ST_DROP: begin
        // The owed response retires the drop even if another redirect arrives.
        if (imem.imem_rvalid) state_next = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase
  end

  // Output / datapath control
  always_comb begin
    imem.imem_req = 1'b0;
    buf_load      = 1'b0;
    hold_load     = 1'b0;
    promote       = 1'b0;
    case (state_reg)
      ST_FETCH: imem.imem_req = ~redirect & ~reset;
      ST_WAIT: begin
        if (!redirect && imem.imem_rvalid) begin
          buf_load  = ~buf_valid | consume;
          hold_load = buf_valid & ~consume;
        end
      end
      ST_HOLD: promote = ~redirect & ~stall;
      default: ;
    endcase
  end

  // PC register; advances only when a response is actually kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= RESET_PC;
    end else if (redirect) begin
      pc_reg <= align_pc(redirect_pc);
    end else if (state_reg == ST_WAIT && imem.imem_rvalid) begin
      pc_reg <= pc_reg + PC_STEP;
    end
  end

  assign imem.imem_addr = pc_reg;
  assign fl_flush       = reset | redirect;

  fetch_skid_buffer u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .stall     (stall),
    .load      (buf_load),
    .hold_load (hold_load),
    .promote   (promote),
    .in_pc     (pc_reg),
    .in_instr  (imem.imem_rdata),
    .valid     (buf_valid),
    .pc        (fl_pc),
    .instr     (fl_instr)
  );

  assign fl_valid = buf_valid;

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed bench for fetch_controller with a
// queue-based reference model and literal spot checks.
module tb_fetch_controller;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fl_valid, fl_flush;
  logic [31:0] fl_pc, fl_instr;

  // second instance with a wrapping reset PC
  logic        stall1 = 1'b0;
  logic        redirect1 = 1'b0;
  logic [31:0] redirect_pc1 = '0;
  logic        fl_valid1, fl_flush1;
  logic [31:0] fl_pc1, fl_instr1;
  bit          en1 = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_if bus0 ();
  fetch_if bus1 ();

  always #5 clk = ~clk;

  initial begin
    bus0.imem_gnt = 0; bus0.imem_rvalid = 0; bus0.imem_rdata = '0;
    bus1.imem_gnt = 0; bus1.imem_rvalid = 0; bus1.imem_rdata = '0;
  end

  fetch_controller dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(bus0), .fl_valid(fl_valid),
    .fl_pc(fl_pc), .fl_instr(fl_instr), .fl_flush(fl_flush)
  );

  fetch_controller #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut1 (
    .clk(clk), .reset(reset), .stall(stall1), .redirect(redirect1),
    .redirect_pc(redirect_pc1), .imem(bus1), .fl_valid(fl_valid1),
    .fl_pc(fl_pc1), .fl_instr(fl_instr1), .fl_flush(fl_flush1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Fetched instructions awaiting presentation form a queue; the head is
  // what the latch shows. At most two can exist (latch + one spare).
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_pc = '0;
  bit          m_out = 0;    // a response is owed by memory
  bit          m_doom = 0;   // that response must be thrown away
  bit          m_live = 0;

  function automatic bit m_req();
    return !reset && !redirect && !m_out && (m_q.size() < 2);
  endfunction

  always @(posedge clk) begin
    bit req_now;
    if (reset) begin
      m_q.delete();
      m_pc = 32'h0; m_out = 0; m_doom = 0; m_live = 1;
    end else if (m_live) begin
      if (redirect) begin
        m_q.delete();
        if (m_out) begin
          if (bus0.imem_rvalid) begin m_out = 0; m_doom = 0; end
          else m_doom = 1;
        end
        m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        req_now = m_req();
        if (m_q.size() > 0 && !stall) void'(m_q.pop_front());
        if (m_out && bus0.imem_rvalid) begin
          if (!m_doom) begin
            m_q.push_back('{pc: m_pc, instr: bus0.imem_rdata});
            $display("[TB] fetch pc=%h instr=%h", m_pc, bus0.imem_rdata);
            m_pc = m_pc + 32'd4;
          end
          m_out = 0; m_doom = 0;
        end
        if (req_now && bus0.imem_gnt) m_out = 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    bit exp_req;
    if (m_live && !reset) begin
      exp_req = m_req();
      chk("fl_valid", {31'b0, fl_valid}, {31'b0, m_q.size() > 0});
      if (m_q.size() > 0) begin
        chk("fl_pc", fl_pc, m_q[0].pc);
        chk("fl_instr", fl_instr, m_q[0].instr);
      end
      chk("imem_req", {31'b0, bus0.imem_req}, {31'b0, exp_req});
      if (exp_req) chk("imem_addr", bus0.imem_addr, m_pc);
      chk("fl_flush", {31'b0, fl_flush}, {31'b0, redirect});
    end
  end

  // One stimulus cycle: inputs change just after the edge, then wait
  // for the falling edge so the caller can sample.
  task automatic cyc(input bit rst, input bit st, input bit rd, input logic [31:0] rpc,
                     input bit g, input bit rv, input logic [31:0] data);
    @(posedge clk); #1;
    reset = rst; stall = st; redirect = rd; redirect_pc = rpc;
    bus0.imem_gnt = g; bus0.imem_rvalid = rv; bus0.imem_rdata = data;
    bus1.imem_gnt = g & en1; bus1.imem_rvalid = rv & en1; bus1.imem_rdata = data;
    @(negedge clk);
  endtask

  initial begin
    // reset
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_req", {31'b0, bus0.imem_req}, 32'd0);
    chk("rst_flush", {31'b0, fl_flush}, 32'd1);
    // back-to-back fetches
    cyc(0, 0, 0, 0, 1, 0, 0);                     // c1
    chk("c1_valid", {31'b0, fl_valid}, 32'd0);
    chk("c1_flpc", fl_pc, 32'h0);
    chk("c1_flinstr", fl_instr, 32'h0);
    chk("c1_addr", bus0.imem_addr, 32'h0);
    chk("c1_addr1", bus1.imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 1, 32'h13);                // c2
    chk("c2_req", {31'b0, bus0.imem_req}, 32'd0);
    en1 = 0;
    cyc(0, 0, 0, 0, 1, 0, 0);                     // c3
    chk("c3_flpc", fl_pc, 32'h0);
    chk("c3_addr", bus0.imem_addr, 32'h4);
    chk("c3_addr1_wrap", bus1.imem_addr, 32'h0);
    chk("c3_flpc1", fl_pc1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 1, 32'h13);                // c4
    chk("c4_valid", {31'b0, fl_valid}, 32'd0);
    cyc(0, 0, 0, 0, 1, 0, 0);                     // c5
    chk("c5_flpc", fl_pc, 32'h4);
    chk("c5_addr", bus0.imem_addr, 32'h8);
    cyc(0, 0, 0, 0, 0, 1, 32'h13);                // c6
    // stall with full latch, response goes to the hold slot
    cyc(0, 1, 0, 0, 1, 0, 0);                     // c7
    chk("c7_flpc", fl_pc, 32'h8);
    chk("c7_addr", bus0.imem_addr, 32'hC);
    cyc(0, 1, 0, 0, 0, 1, 32'hA);                 // c8
    cyc(0, 1, 0, 0, 0, 0, 0);                     // c9
    chk("c9_req_hold", {31'b0, bus0.imem_req}, 32'd0);
    chk("c9_flpc", fl_pc, 32'h8);
    cyc(0, 1, 0, 0, 0, 0, 0);                     // c10
    cyc(0, 0, 0, 0, 0, 0, 0);                     // c11
    chk("c11_flpc", fl_pc, 32'h8);
    cyc(0, 0, 0, 0, 1, 0, 0);                     // c12
    chk("c12_flpc", fl_pc, 32'hC);
    chk("c12_flinstr", fl_instr, 32'hA);
    chk("c12_addr", bus0.imem_addr, 32'h10);
    // redirect while waiting for a response
    cyc(0, 0, 1, 32'h100, 0, 0, 0);               // c13
    chk("c13_flush", {31'b0, fl_flush}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);                     // c14
    chk("c14_req_drop", {31'b0, bus0.imem_req}, 32'd0);
    cyc(0, 0, 0, 0, 0, 1, 32'hDEADBEEF);          // c15
    cyc(0, 0, 0, 0, 1, 0, 0);                     // c16
    chk("c16_valid", {31'b0, fl_valid}, 32'd0);
    chk("c16_addr", bus0.imem_addr, 32'h100);
    cyc(0, 0, 0, 0, 0, 1, 32'h11);                // c17
    cyc(0, 0, 0, 0, 1, 0, 0);                     // c18
    chk("c18_flpc", fl_pc, 32'h100);
    // redirect coinciding with rvalid, unaligned target
    cyc(0, 0, 1, 32'h103, 0, 1, 32'hBAD);         // c19
    cyc(0, 1, 0, 0, 1, 0, 0);                     // c20
    chk("c20_addr", bus0.imem_addr, 32'h100);
    chk("c20_valid", {31'b0, fl_valid}, 32'd0);
    cyc(0, 1, 0, 0, 0, 1, 32'h22);                // c21
    cyc(0, 1, 0, 0, 1, 0, 0);                     // c22
    chk("c22_flinstr", fl_instr, 32'h22);
    chk("c22_addr", bus0.imem_addr, 32'h104);
    cyc(0, 1, 0, 0, 0, 1, 32'h33);                // c23
    // redirect while stalled in hold
    cyc(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0);         // c24
    chk("c24_req", {31'b0, bus0.imem_req}, 32'd0);
    cyc(0, 0, 0, 0, 1, 0, 0);                     // c25
    chk("c25_valid", {31'b0, fl_valid}, 32'd0);
    chk("c25_addr", bus0.imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 1, 32'h44);                // c26
    cyc(0, 1, 0, 0, 1, 0, 0);                     // c27
    chk("c27_flpc", fl_pc, 32'hFFFF_FFFC);
    chk("c27_addr_wrap", bus0.imem_addr, 32'h0);
    cyc(0, 1, 0, 0, 0, 1, 32'h55);                // c28
    // reset while in hold with stall
    cyc(1, 1, 0, 0, 0, 0, 0);                     // c29
    chk("c29_req", {31'b0, bus0.imem_req}, 32'd0);
    chk("c29_flush", {31'b0, fl_flush}, 32'd1);
    cyc(0, 1, 0, 0, 0, 1, 32'h66);                // c30 stray rvalid
    chk("c30_valid", {31'b0, fl_valid}, 32'd0);
    chk("c30_addr", bus0.imem_addr, 32'h0);
    chk("c30_req", {31'b0, bus0.imem_req}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);                     // c31
    chk("c31_valid", {31'b0, fl_valid}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
